// File: rtl/hazard_pkg.sv
// Shared definitions for the data-hazard unit: forwarding-select encoding and the
// in-flight producer record tracked for EX, MEM and WB.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [1:0] FWD_RET = 2'b11;

  // Entries carry a fixed-width destination so the struct stays parameter-free;
  // narrower register numbers are zero-extended before storage and comparison.
  localparam int unsigned MAX_REG_ADDR_W = 8;

  typedef struct packed {
    logic                      valid;
    logic [MAX_REG_ADDR_W-1:0] dst;
    logic                      wr;
    logic                      wr_imp;
    logic                      is_load;
  } pipe_entry_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage request and forwarding/stall response bundle of the hazard unit.
interface hazard_forward_unit_if #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned CNT_W      = 16
);
  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
  logic [NUM_SRC-1:0]            id_src_used;
  logic [REG_ADDR_W-1:0]         id_dst;
  logic                          id_wr;
  logic                          id_wr_imp;
  logic                          id_is_load;
  logic                          flush;
  logic                          hold;
  logic                          stall;
  logic [2*NUM_SRC-1:0]          fwd_sel_ex;
  logic [NUM_SRC-1:0]            fwd_imp_ex;
  logic [CNT_W-1:0]              stall_cnt;

  modport master (
    output id_valid, id_src, id_src_used, id_dst, id_wr, id_wr_imp, id_is_load, flush, hold,
    input  stall, fwd_sel_ex, fwd_imp_ex, stall_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_dst, id_wr, id_wr_imp, id_is_load, flush, hold,
    output stall, fwd_sel_ex, fwd_imp_ex, stall_cnt
  );
endinterface

// File: rtl/hazard_src_match.sv
// Single-operand comparator: finds the nearest in-flight producer of one source
// register and flags a load-use hit against the instruction in EX.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 4,
  parameter int unsigned IMPLICIT_REG = 0
) (
  input  logic                  need_i,
  input  logic [REG_ADDR_W-1:0] src_i,
  input  pipe_entry_t [2:0]     ent_i,
  output logic [1:0]            sel_o,
  output logic                  imp_o,
  output logic                  load_hit_o
);

  localparam logic [MAX_REG_ADDR_W-1:0] ImpReg = MAX_REG_ADDR_W'(IMPLICIT_REG);

  logic [MAX_REG_ADDR_W-1:0] src_ext;
  logic [2:0]                prim_hit;
  logic [2:0]                imp_hit;

  assign src_ext = MAX_REG_ADDR_W'(src_i);

  always_comb begin
    prim_hit = '0;
    imp_hit  = '0;
    for (int k = 0; k < 3; k++) begin
      prim_hit[k] = ent_i[k].valid & ent_i[k].wr & (ent_i[k].dst == src_ext);
      imp_hit[k]  = ent_i[k].valid & ent_i[k].wr_imp & (src_ext == ImpReg);
    end
  end

  // Nearest stage wins; within a stage the primary result beats the implicit one.
  always_comb begin
    sel_o = FWD_RF;
    imp_o = 1'b0;
    if (need_i) begin
      if (prim_hit[0] | imp_hit[0]) begin
        sel_o = FWD_MEM;
        imp_o = ~prim_hit[0];
      end else if (prim_hit[1] | imp_hit[1]) begin
        sel_o = FWD_WB;
        imp_o = ~prim_hit[1];
      end else if (prim_hit[2] | imp_hit[2]) begin
        sel_o = FWD_RET;
        imp_o = ~prim_hit[2];
      end
    end
    load_hit_o = need_i & prim_hit[0] & ent_i[0].is_load;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Data-hazard unit: tracks EX/MEM/WB producers, raises load-use stalls and
// registers per-operand forwarding selects for the instruction entering EX.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 4,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned IMPLICIT_REG = 0,
  parameter int unsigned CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst,
  hazard_forward_unit_if.slave bus
);

  pipe_entry_t [2:0]    ent_q, ent_d;
  pipe_entry_t          id_ent;
  logic [2*NUM_SRC-1:0] sel_calc, fwd_sel_q, fwd_sel_d;
  logic [NUM_SRC-1:0]   imp_calc, load_hit, fwd_imp_q, fwd_imp_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 stall;
  logic                 advance;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_match #(
      .REG_ADDR_W  (REG_ADDR_W),
      .IMPLICIT_REG(IMPLICIT_REG)
    ) u_match (
      .need_i    (bus.id_valid & bus.id_src_used[i]),
      .src_i     (bus.id_src[i*REG_ADDR_W +: REG_ADDR_W]),
      .ent_i     (ent_q),
      .sel_o     (sel_calc[2*i +: 2]),
      .imp_o     (imp_calc[i]),
      .load_hit_o(load_hit[i])
    );
  end

  always_comb begin
    id_ent         = '0;
    id_ent.valid   = 1'b1;
    id_ent.dst     = MAX_REG_ADDR_W'(bus.id_dst);
    id_ent.wr      = bus.id_wr;
    id_ent.wr_imp  = bus.id_wr_imp;
    id_ent.is_load = bus.id_is_load;
  end

  // Flush kills the consumer, so a pending load-use hazard no longer matters.
  assign stall   = (|load_hit) & ~bus.flush;
  assign advance = bus.id_valid & ~stall & ~bus.flush;

  always_comb begin
    ent_d     = ent_q;
    fwd_sel_d = fwd_sel_q;
    fwd_imp_d = fwd_imp_q;
    cnt_d     = cnt_q;
    if (!bus.hold) begin
      ent_d[2]  = ent_q[1];
      ent_d[1]  = ent_q[0];
      ent_d[0]  = advance ? id_ent : '0;
      fwd_sel_d = advance ? sel_calc : '0;
      fwd_imp_d = advance ? imp_calc : '0;
      if (stall && !(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q     <= '0;
      fwd_sel_q <= '0;
      fwd_imp_q <= '0;
      cnt_q     <= '0;
    end else begin
      ent_q     <= ent_d;
      fwd_sel_q <= fwd_sel_d;
      fwd_imp_q <= fwd_imp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.stall      = stall;
  assign bus.fwd_sel_ex = fwd_sel_q;
  assign bus.fwd_imp_ex = fwd_imp_q;
  assign bus.stall_cnt  = cnt_q;

endmodule
